matrix_scan_driver: RTL
=======================

Name: matrix_scan_driver

Overview:
- Parametrised column-multiplexed LED-matrix driver; successor to the fixed 5x7 column scanner.
- Scans COLS columns of ROWS pixels from a double-buffered frame image, one-hot column activation.
- Adds per-column PWM brightness, a programmable scan-rate divider, a frame-load/ack handshake with tear-free swap at frame boundary, and output polarity selection.
- Sits between the image-generation logic and the matrix pins.

Parameters:
- ROWS, 7, pixels per column (width of colune_data).
- COLS, 5, number of columns (width of colune_activator); must be >= 2.
- BRIGHT_W, 2, brightness width; dwell per column = 2**BRIGHT_W ticks.
- TICK_DIV, 1, clocks per dwell tick; must be >= 1 (1 = every clock).
- ROW_ACTIVE_LOW, 0, 1 = colune_data bits driven inverted.
- COL_ACTIVE_LOW, 0, 1 = colune_activator driven inverted.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  scan enable; low = blank and rewind scan.
- frame  in  ROWS*COLS  new image; column c = frame[c*ROWS +: ROWS].
- frame_load  in  1  single-cycle request to capture frame into staging.
- brightness  in  BRIGHT_W  duty value, sampled at each frame boundary.
- frame_ack  out  1  one-cycle pulse: staging copied into active buffer.
- frame_start  out  1  one-cycle pulse when column 0 dwell begins.
- colune_data  out  ROWS  pixel data for the lit column.
- colune_activator  out  COLS  one-hot column select.

Behaviour:
- Reset (sync): active, staging, pending, tick_cnt, dwell_cnt, col_idx, bright_q all 0; frame_ack = frame_start = 0; colune_data, colune_activator at inactive level (all 0, or all 1 if the matching ACTIVE_LOW is set). Reset overrides every other input.
- Counters: tick_cnt 0..TICK_DIV-1 every clk; tick = (tick_cnt == TICK_DIV-1). On tick, dwell_cnt 0..2**BRIGHT_W-1 wraps. On dwell wrap, col_idx 0..COLS-1 wraps to 0. Frame boundary = tick & dwell wrap & col_idx == COLS-1.
- Frame period = COLS * 2**BRIGHT_W * TICK_DIV clocks.
- Lit condition: enable & (dwell_cnt < bright_q). bright_q = 0 means dark; max duty = (2**BRIGHT_W-1)/2**BRIGHT_W.
- Outputs are registered with one clock of latency from counter state. When lit: colune_activator = one-hot(col_idx), colune_data = active[col_idx]. Otherwise both are inactive. Polarity inversion is applied last.
- frame_start: registered pulse in the cycle outputs first show col_idx 0, dwell_cnt 0, tick_cnt 0 (including the first scan after enable rises).
- Handshake: frame_load = 1 -> staging <= frame, pending <= 1.
  - At a frame boundary with pending = 1: active <= staging, bright_q <= brightness, pending <= 0, frame_ack = 1 next cycle.
  - At a boundary with pending = 0: only bright_q updates.
- Multiple loads before a boundary: last one wins; a single ack is issued.
- frame_load in the same cycle as a boundary: the boundary transfers the old staging (if pending). The new data is captured, pending stays 1, and it transfers at the next boundary.
- enable low: tick_cnt, dwell_cnt, col_idx forced to 0 each cycle; outputs inactive; no boundaries, so no acks. Staging/pending/active are kept, and frame_load is still accepted.
- enable rise: scan restarts at column 0.
- Reset mid-frame: all state cleared next edge, pending load discarded, no ack.

Decomposition:
- Shared package: row/column width localparams, a clog2 function, polarity-apply function, frame slice index helper.
- One sub-module: scan_timer (tick divider, dwell counter, column counter; outputs tick, dwell_cnt, col_idx, boundary).
- Buffering, PWM compare and output registers stay in the top.

Test Plan (ROWS=7, COLS=5, BRIGHT_W=2, TICK_DIV=1 unless noted):
- Reset held 3 cycles, enable=1 -> all outputs 0, frame_ack/frame_start 0; first cycle after release still inactive (bright_q=0).
- frame_load with frame = {5{7'h55}} ^ col pattern, brightness=3 -> frame_ack exactly once at cycle 20 boundary. Next frame: column c lit 3 of 4 cycles with colune_activator=1<<c, colune_data=active slice c. frame_start every 20 cycles.
- brightness=1 -> each column lit 1 of 4 cycles; brightness=0 -> fully dark for the whole frame, frame_start still pulses.
- Two loads A then B within one frame, and a load C coincident with the boundary -> boundary shows B with one ack; C is shown one frame later with a second ack.
- TICK_DIV=3 -> frame period 60 clocks, each column activated for 3*bright_q consecutive clocks.
- enable dropped mid-column 2, then raised after 7 cycles -> outputs inactive while low; restart at column 0 with frame_start; a pending load is preserved and acked at the next boundary. Reset asserted mid-frame with a pending load -> no ack, active cleared.
- ROW_ACTIVE_LOW=1, COL_ACTIVE_LOW=1 -> idle outputs 7'h7F/5'h1F; lit column 0 gives colune_activator=5'h1E and colune_data=~slice.

Source files
------------

// File: rtl/matrix_scan_driver_pkg.sv
// matrix_scan_driver_pkg: shared widths and helpers for the LED-matrix scan driver
// Contents: default geometry, clog2, per-bit polarity apply, frame slice base index.
package matrix_scan_driver_pkg;
    localparam int DEF_ROWS = 7;
    localparam int DEF_COLS = 5;
    localparam int DEF_BRIGHT_W = 2;
    // Ceiling log2, never below 1 so counters of range 1 still get a bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction
    function automatic logic apply_pol(input logic b, input bit inv);
        return b ^ inv;
    endfunction
    // Column c of a packed frame starts at bit c*rows.
    function automatic int slice_lo(input int c, input int rows);
        return c * rows;
    endfunction
endpackage

// File: rtl/matrix_scan_driver_if.sv
// matrix_scan_driver_if: image-side and pin-side signals of the scan driver
// master: image source (drives enable/frame/frame_load/brightness); slave: the driver.
interface matrix_scan_driver_if
    import matrix_scan_driver_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int BRIGHT_W = DEF_BRIGHT_W
);
    logic enable;
    logic [ROWS*COLS-1:0] frame;
    logic frame_load;
    logic [BRIGHT_W-1:0] brightness;
    logic frame_ack;
    logic frame_start;
    logic [ROWS-1:0] colune_data;
    logic [COLS-1:0] colune_activator;
    modport master (
        output enable, frame, frame_load, brightness,
        input frame_ack, frame_start, colune_data, colune_activator
    );
    modport slave (
        input enable, frame, frame_load, brightness,
        output frame_ack, frame_start, colune_data, colune_activator
    );
endinterface

// File: rtl/matrix_scan_driver_scan_timer.sv
// matrix_scan_driver_scan_timer: tick divider, PWM dwell counter and column counter
// Ports: clk, reset (sync, active-high), enable_i; dwell_cnt_o, col_idx_o,
//        first_o (all counters at zero), boundary_o (last clock of a frame).
module matrix_scan_driver_scan_timer
    import matrix_scan_driver_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int BRIGHT_W = DEF_BRIGHT_W,
    parameter int TICK_DIV = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable_i,
    output logic [BRIGHT_W-1:0]       dwell_cnt_o,
    output logic [clog2(COLS)-1:0]    col_idx_o,
    output logic                      first_o,
    output logic                      boundary_o
);
    localparam int CW = clog2(COLS);
    localparam int TW = clog2(TICK_DIV);
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [BRIGHT_W-1:0] dwell_q, dwell_d;
    logic [CW-1:0] col_q, col_d;
    logic tick, dwell_wrap, col_last;
    always_comb begin
        tick = tick_cnt_q == TW'(TICK_DIV - 1);
        dwell_wrap = dwell_q == '1;
        col_last = col_q == CW'(COLS - 1);
        // Disabled scan holds every counter at zero so a rise restarts at column 0.
        tick_cnt_d = (!enable_i || tick) ? '0 : tick_cnt_q + 1'b1;
        dwell_d = !enable_i ? '0 : tick ? dwell_q + 1'b1 : dwell_q;
        col_d = !enable_i ? '0 : (tick && dwell_wrap) ? (col_last ? '0 : col_q + 1'b1) : col_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
            dwell_q <= '0;
            col_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            dwell_q <= dwell_d;
            col_q <= col_d;
        end
    end
    assign dwell_cnt_o = dwell_q;
    assign col_idx_o = col_q;
    assign first_o = tick_cnt_q == '0 && dwell_q == '0 && col_q == '0;
    assign boundary_o = enable_i && tick && dwell_wrap && col_last;
endmodule

// File: rtl/matrix_scan_driver.sv
// matrix_scan_driver: column-multiplexed LED-matrix driver with PWM, tear-free frame swap and polarity select
// Ports: clk, reset (sync, active-high); bus (slave): enable, frame, frame_load, brightness in;
//        frame_ack, frame_start, colune_data, colune_activator out (all registered).
module matrix_scan_driver
    import matrix_scan_driver_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int BRIGHT_W = DEF_BRIGHT_W,
    parameter int TICK_DIV = 1,
    parameter int ROW_ACTIVE_LOW = 0,
    parameter int COL_ACTIVE_LOW = 0
) (
    input logic clk,
    input logic reset,
    matrix_scan_driver_if.slave bus
);
    localparam int CW = clog2(COLS);
    localparam int FW = clog2(ROWS * COLS);
    localparam bit RI = ROW_ACTIVE_LOW != 0;
    localparam bit CI = COL_ACTIVE_LOW != 0;
    logic [BRIGHT_W-1:0] dwell_cnt, bright_q;
    logic [CW-1:0] col_idx;
    logic first, boundary, lit;
    logic pending_q, ack_q, start_q;
    logic [ROWS*COLS-1:0] staging_q, active_q;
    logic [FW-1:0] base;
    logic [ROWS-1:0] data_raw, data_d, data_q;
    logic [COLS-1:0] act_raw, act_d, act_q;
    matrix_scan_driver_scan_timer #(
        .COLS(COLS),
        .BRIGHT_W(BRIGHT_W),
        .TICK_DIV(TICK_DIV)
    ) u_timer (
        .clk(clk),
        .reset(reset),
        .enable_i(bus.enable),
        .dwell_cnt_o(dwell_cnt),
        .col_idx_o(col_idx),
        .first_o(first),
        .boundary_o(boundary)
    );
    always_comb begin
        // PWM: the column is lit for the first bright_q dwell ticks of its slot.
        lit = bus.enable && (dwell_cnt < bright_q);
        base = FW'(slice_lo(int'(col_idx), ROWS));
        data_raw = lit ? active_q[base +: ROWS] : '0;
        act_raw = lit ? ({{(COLS-1){1'b0}}, 1'b1} << col_idx) : '0;
        data_d = '0;
        act_d = '0;
        for (int i = 0; i < ROWS; i++) data_d[i] = apply_pol(data_raw[i], RI);
        for (int i = 0; i < COLS; i++) act_d[i] = apply_pol(act_raw[i], CI);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            staging_q <= '0;
            active_q <= '0;
            pending_q <= 1'b0;
            bright_q <= '0;
            ack_q <= 1'b0;
            start_q <= 1'b0;
            data_q <= {ROWS{RI}};
            act_q <= {COLS{CI}};
        end else begin
            // Swap only at the frame boundary; a load in that same cycle stays pending.
            if (boundary) begin
                bright_q <= bus.brightness;
                if (pending_q) active_q <= staging_q;
            end
            if (bus.frame_load) staging_q <= bus.frame;
            pending_q <= bus.frame_load || (pending_q && !boundary);
            ack_q <= boundary && pending_q;
            start_q <= bus.enable && first;
            data_q <= data_d;
            act_q <= act_d;
        end
    end
    assign bus.frame_ack = ack_q;
    assign bus.frame_start = start_q;
    assign bus.colune_data = data_q;
    assign bus.colune_activator = act_q;
endmodule
